hssi_ss_delay_align_ctrl: RTL and testbench
===========================================

HSSI_SS_DELAY_ALIGN_CTRL -- requirements
Module: hssi_ss_delay_align_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits carried by the aligned path.
REQ-002 SHALL have parameter MAX_DELAY, default 15: largest programmable delay in cycles, legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT, default 255: cycles allowed in WAIT_MARK before error, legal range 1..65535.
REQ-004 SHALL have port clk  input  1  the single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  single-cycle pulse requesting a new alignment.
REQ-007 SHALL have port ref_mark  input  1  alignment marker on the reference lane.
REQ-008 SHALL have port din  input  WIDTH  data on the lane being aligned.
REQ-009 SHALL have port din_mark  input  1  alignment marker accompanying din.
REQ-010 SHALL have port dout  output  WIDTH  din delayed by delay_val cycles.
REQ-011 SHALL have port dout_mark  output  1  din_mark delayed by delay_val cycles.
REQ-012 SHALL have port delay_val  output  DW=clog2(MAX_DELAY+1)  currently applied delay.
REQ-013 SHALL have port busy  output  1  high in WAIT_MARK, MEASURE and SETTLE.
REQ-014 SHALL have ports locked and err  output  1 each  status flags, mutually exclusive.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MARK, MEASURE, SETTLE, LOCKED, ERROR.
REQ-016 SHALL leave IDLE, LOCKED or ERROR for WAIT_MARK on start; it SHALL clear locked and err and zero the timeout counter on that edge, and keep delay_val unchanged.
REQ-017 SHALL ignore start while busy.
REQ-018 In WAIT_MARK, din_mark and ref_mark in the same cycle SHALL load delay_val=0 and go to SETTLE.
REQ-019 In WAIT_MARK, din_mark without ref_mark SHALL set measure count=1 and go to MEASURE; ref_mark alone SHALL be ignored.
REQ-020 In WAIT_MARK, TIMEOUT consecutive cycles without din_mark SHALL go to ERROR.
REQ-021 In MEASURE, ref_mark SHALL load delay_val=count and go to SETTLE; otherwise count SHALL increment by one.
REQ-022 In MEASURE, count==MAX_DELAY without ref_mark SHALL go to ERROR, leave delay_val unchanged, and ignore further din_mark.
REQ-023 SETTLE SHALL last exactly MAX_DELAY cycles and then go to LOCKED, flushing stale taps.
REQ-024 locked SHALL be 1 only in LOCKED; err SHALL be 1 only in ERROR; both SHALL be registered state decodes.
REQ-025 Delay line SHALL be a MAX_DELAY-deep register chain of WIDTH+1 bits ({din_mark,din}) that shifts every cycle, with no enable.
REQ-026 delay_val=0 SHALL pass {din_mark,din} combinationally; delay_val=N SHALL present the input from exactly N cycles earlier.
REQ-027 delay_val SHALL change only on the WAIT_MARK/MEASURE to SETTLE transition.

Reset
REQ-028 Asserting rst_n low at any time, including mid-measure, SHALL force IDLE, delay_val=0, busy=0, locked=0, err=0, and zero all counters.
REQ-029 Delay-line data registers SHALL NOT be reset; dout and dout_mark SHALL be treated as undefined until MAX_DELAY cycles after reset release.

Structure
REQ-030 State encoding type, DW width function and the MAX_DELAY/TIMEOUT defaults SHALL live in shared package hssi_ss_delay_align_pkg.
REQ-031 Tap-selectable delay line SHALL be a sub-module hssi_ss_var_delay (params WIDTH, MAX_DELAY; ports clk, din, sel, dout).
REQ-032 FSM and counters SHALL be in the top level; target size 120-400 lines RTL.

Verification
REQ-033 Defaults; start, din_mark at t, ref_mark at t+5 -> delay_val=5, SETTLE 15 cycles, locked=1; dout_mark aligned with ref_mark thereafter.
REQ-034 din_mark and ref_mark same cycle -> delay_val=0; dout==din combinationally; locked after 15 cycles.
REQ-035 din_mark, no ref_mark for 15 cycles -> err=1, locked=0, delay_val holds prior value.
REQ-036 TIMEOUT=20; start, no din_mark -> err=1 on cycle 20 after start; a second start clears err and busy=1.
REQ-037 rst_n low mid-MEASURE at count 7 -> IDLE, delay_val=0, all flags 0 immediately; start pulse during SETTLE has no effect.

Source files
------------

// File: rtl/hssi_ss_delay_align_pkg.sv
// Shared definitions for the HSSI lane delay-alignment controller:
// FSM state type, parameter defaults and the delay-select width helper.
package hssi_ss_delay_align_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_DELAY = 15;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_MARK = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_ERROR     = 3'd5
  } align_state_t;

  // Width of a value able to hold 0..max_delay.
  function automatic int delay_width(input int max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/hssi_ss_var_delay.sv
// Free-running register delay line with a tap select; sel=0 is a
// combinational bypass, sel=N returns the input from N cycles earlier.
module hssi_ss_var_delay
  import hssi_ss_delay_align_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  MAX_DELAY = DEF_MAX_DELAY,
  localparam int DW        = delay_width(MAX_DELAY)
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] din,
  input  logic [DW-1:0]    sel,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] tap [MAX_DELAY+1];

  assign tap[0] = din;

  // Data stages carry no reset so they map onto plain shift registers.
  for (genvar gi = 1; gi <= MAX_DELAY; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_reg;

    always_ff @(posedge clk) begin
      stage_reg <= tap[gi-1];
    end

    assign tap[gi] = stage_reg;
  end

  always_comb begin
    dout = din;
    for (int i = 1; i <= MAX_DELAY; i++) begin
      if (int'(sel) == i) begin
        dout = tap[i];
      end
    end
  end

endmodule

// File: rtl/hssi_ss_delay_align_ctrl.sv
// Measures the marker skew between a lane and the reference lane, then
// delays the lane by that many cycles so both markers line up.
module hssi_ss_delay_align_ctrl
  import hssi_ss_delay_align_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  MAX_DELAY = DEF_MAX_DELAY,
  parameter int  TIMEOUT   = DEF_TIMEOUT,
  localparam int DW        = delay_width(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ref_mark,
  input  logic [WIDTH-1:0] din,
  input  logic             din_mark,
  output logic [WIDTH-1:0] dout,
  output logic             dout_mark,
  output logic [DW-1:0]    delay_val,
  output logic             busy,
  output logic             locked,
  output logic             err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] MAX_CNT     = DW'(MAX_DELAY);
  localparam logic [DW-1:0] SETTLE_LAST = DW'(MAX_DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

  align_state_t     state_reg, state_next;
  logic [DW-1:0]    cnt_reg, cnt_next;
  logic [DW-1:0]    settle_reg, settle_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic [DW-1:0]    delay_reg, delay_next;
  logic             locked_reg, err_reg;
  logic [WIDTH:0]   line_out;

  // State and counter registers; flags decode the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      settle_reg <= '0;
      tmo_reg    <= '0;
      delay_reg  <= '0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      settle_reg <= settle_next;
      tmo_reg    <= tmo_next;
      delay_reg  <= delay_next;
      locked_reg <= (state_next == ST_LOCKED);
      err_reg    <= (state_next == ST_ERROR);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    settle_next = settle_reg;
    tmo_next    = tmo_reg;
    delay_next  = delay_reg;

    case (state_reg)
      ST_IDLE, ST_LOCKED, ST_ERROR: begin
        if (start) begin
          state_next = ST_WAIT_MARK;
          tmo_next   = '0;
        end
      end

      ST_WAIT_MARK: begin
        if (din_mark && ref_mark) begin
          delay_next  = '0;
          settle_next = '0;
          state_next  = ST_SETTLE;
        end else if (din_mark) begin
          cnt_next   = DW'(1);
          state_next = ST_MEASURE;
        end else if (tmo_reg == TMO_LAST) begin
          state_next = ST_ERROR;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end

      ST_MEASURE: begin
        if (ref_mark) begin
          delay_next  = cnt_reg;
          settle_next = '0;
          state_next  = ST_SETTLE;
        end else if (cnt_reg == MAX_CNT) begin
          state_next = ST_ERROR;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // Hold off lock until every tap has been refilled with current data.
      ST_SETTLE: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next = ST_LOCKED;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_reg == ST_WAIT_MARK) ||
                (state_reg == ST_MEASURE)   ||
                (state_reg == ST_SETTLE);
    locked    = locked_reg;
    err       = err_reg;
    delay_val = delay_reg;
    dout      = line_out[WIDTH-1:0];
    dout_mark = line_out[WIDTH];
  end

  hssi_ss_var_delay #(
    .WIDTH     (WIDTH + 1),
    .MAX_DELAY (MAX_DELAY)
  ) u_var_delay (
    .clk  (clk),
    .din  ({din_mark, din}),
    .sel  (delay_reg),
    .dout (line_out)
  );

endmodule

// File: tb/tb_hssi_ss_delay_align_ctrl.sv
// Directed-plus-random bench for hssi_ss_delay_align_ctrl; expectations come
// from the marker-gap rules and an input history of the aligned lane.
module tb_hssi_ss_delay_align_ctrl;

  localparam int WIDTH = 8;
  localparam int MD    = 15;
  localparam int TMO   = 20;
  localparam int DW    = $clog2(MD + 1);

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic             ref_mark = 1'b0;
  logic             din_mark = 1'b0;
  logic [WIDTH-1:0] din      = '0;
  logic [WIDTH-1:0] dout;
  logic             dout_mark;
  logic [DW-1:0]    delay_val;
  logic             busy;
  logic             locked;
  logic             err;

  int errors    = 0;
  int checks    = 0;
  int exp_delay = 0;

  // hist[k] is the {din_mark,din} sampled k+1 clock edges ago.
  logic [WIDTH:0] hist [$];

  always #5 clk = ~clk;

  hssi_ss_delay_align_ctrl #(
    .WIDTH     (WIDTH),
    .MAX_DELAY (MD),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ref_mark  (ref_mark),
    .din       (din),
    .din_mark  (din_mark),
    .dout      (dout),
    .dout_mark (dout_mark),
    .delay_val (delay_val),
    .busy      (busy),
    .locked    (locked),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    hist.push_front({din_mark, din});
    if (hist.size() > 64) void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input int b, input int l, input int e);
    chk({tag, "_busy"},   32'(busy),   b);
    chk({tag, "_locked"}, 32'(locked), l);
    chk({tag, "_err"},    32'(err),    e);
  endtask

  // Random lane traffic with the aligned output compared to the history.
  task automatic data_run(input int n);
    logic [WIDTH:0] exp;
    for (int i = 0; i < n; i++) begin
      din      = WIDTH'($urandom);
      din_mark = 1'($urandom_range(0, 1));
      #1;
      if (exp_delay == 0) begin
        exp = {din_mark, din};
        chk("dout_bypass", 32'({dout_mark, dout}), 32'(exp));
      end else if (hist.size() >= exp_delay) begin
        exp = hist[exp_delay-1];
        chk("dout_delayed", 32'({dout_mark, dout}), 32'(exp));
      end
      tick();
    end
    din_mark = 1'b0;
  endtask

  // One alignment attempt: ref_mark arrives gap cycles after din_mark.
  task automatic align_trial(input int pre, input int gap, input bit poke_start);
    int prior;
    prior = exp_delay;
    pulse_start();
    chk_flags("start", 1, 0, 0);
    chk("start_hold_delay", 32'(delay_val), prior);
    for (int i = 0; i < pre; i++) begin
      ref_mark = 1'($urandom_range(0, 1));
      tick();
    end
    ref_mark = (gap == 0);
    din_mark = 1'b1;
    tick();
    din_mark = 1'b0;
    ref_mark = 1'b0;
    if (gap <= MD) begin
      if (gap > 0) begin
        for (int i = 1; i < gap; i++) begin
          din_mark = 1'($urandom_range(0, 1));
          tick();
        end
        din_mark = 1'b0;
        ref_mark = 1'b1;
        tick();
        ref_mark = 1'b0;
      end
      exp_delay = gap;
      chk("delay_val", 32'(delay_val), gap);
      chk_flags("settle_enter", 1, 0, 0);
      for (int i = 1; i < MD; i++) begin
        if (poke_start && i == 3) start = 1'b1;
        tick();
        start = 1'b0;
      end
      chk_flags("settle_last", 1, 0, 0);
      tick();
      chk_flags("locked", 0, 1, 0);
      chk("locked_delay", 32'(delay_val), gap);
    end else begin
      for (int i = 1; i < MD; i++) begin
        din_mark = 1'($urandom_range(0, 1));
        tick();
      end
      din_mark = 1'b0;
      chk_flags("measure_last", 1, 0, 0);
      tick();
      chk_flags("measure_err", 0, 0, 1);
      chk("err_hold_delay", 32'(delay_val), prior);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_flags("reset", 0, 0, 0);
    chk("reset_delay", 32'(delay_val), 0);
    rst_n = 1'b1;
    tick();
    chk_flags("idle", 0, 0, 0);

    // din_mark then ref_mark five cycles later
    align_trial(2, 5, 1'b1);
    din_mark = 1'b1;
    tick();
    din_mark = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ref_mark = 1'b1;
    #1;
    chk("mark_align", 32'(dout_mark), 32'(ref_mark));
    tick();
    ref_mark = 1'b0;
    data_run(24);

    // Markers coincide: zero delay, combinational bypass
    align_trial(1, 0, 1'b0);
    data_run(12);

    // Random gaps, including some beyond the measurable range
    for (int t = 0; t < 8; t++) begin
      align_trial($urandom_range(0, 5), $urandom_range(1, MD + 3), t[0]);
      data_run(20);
    end
    align_trial(0, $urandom_range(1, MD), 1'b1);
    align_trial(3, MD + 1, 1'b0);

    // Timeout with no din_mark, then restart from ERROR
    pulse_start();
    for (int i = 1; i < TMO; i++) tick();
    chk_flags("tmo_last", 1, 0, 0);
    tick();
    chk_flags("tmo_err", 0, 0, 1);
    pulse_start();
    chk_flags("restart", 1, 0, 0);

    // Asynchronous reset in the middle of a measurement
    din_mark = 1'b1;
    tick();
    din_mark = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_flags("measuring", 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_flags("midreset", 0, 0, 0);
    chk("midreset_delay", 32'(delay_val), 0);
    exp_delay = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_flags("post_reset", 0, 0, 0);
    align_trial(2, 3, 1'b1);
    data_run(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
